// File: rtl/rr_grant_encoder.sv
// ============================================================================
// rr_grant_encoder: 16-way round-robin arbiter with registered binary grant index.
// Optional forced revocation of long-held grants via macro RR_TIMEOUT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_encoder #(
    parameter int NREQ     = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    // "release" is a reserved word in SystemVerilog, hence the longer name
    input  logic             release_pulse,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_found;
    logic             w_valid_nxt;
    logic             w_timeout_nxt;
    logic             w_end_normal;
    logic             w_hold_expire;

    // Rotating priority search: first set request at or after the pointer wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = r_ptr + IDX_W'(i);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_end_normal = release_pulse | ~req[grant_idx];

`ifdef RR_TIMEOUT_EN
    logic [7:0] r_hold_cnt;

    // Expiry fires while the counter steps onto MAX_HOLD, so a grant lasts MAX_HOLD cycles.
    assign w_hold_expire = (r_state == ST_GRANT) && (r_hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
        end else if (r_state == ST_GRANT) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end else begin
            r_hold_cnt <= 8'd0;
        end
    end
`else
    logic [7:0] w_unused_max_hold;

    assign w_unused_max_hold = 8'(MAX_HOLD);
    assign w_hold_expire     = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = grant_valid;
        w_idx_nxt     = grant_idx;
        w_ptr_nxt     = r_ptr;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_valid_nxt = 1'b1;
                    w_idx_nxt   = w_winner;
                end
            end
            ST_GRANT: begin
                if (w_end_normal || w_hold_expire) begin
                    w_state_nxt   = ST_IDLE;
                    w_valid_nxt   = 1'b0;
                    w_ptr_nxt     = grant_idx + IDX_W'(1);
                    w_timeout_nxt = ~w_end_normal;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            grant_valid <= w_valid_nxt;
            grant_idx   <= w_idx_nxt;
            timeout     <= w_timeout_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_encoder.sv
// ============================================================================
// tb_rr_grant_encoder: vector-table and scoreboard bench for rr_grant_encoder.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_grant_encoder;

`ifdef RR_TIMEOUT_EN
    localparam int C_MAX_HOLD = 4;
`else
    localparam int C_MAX_HOLD = 15;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        release_pulse;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic        timeout;

    typedef struct {
        logic [15:0] req;
        logic        rel;
        logic        exp_valid;
        logic [3:0]  exp_idx;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [3:0] idx;
        logic       to;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    rr_grant_encoder #(
        .NREQ     (16),
        .IDX_W    (4),
        .MAX_HOLD (C_MAX_HOLD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .release_pulse (release_pulse),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input int tag, input logic v, input logic [3:0] ix,
                           input logic t);
        n_checks++;
        if (grant_valid === v && grant_idx === ix && timeout === t) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got valid=%b idx=%0d timeout=%b, expected valid=%b idx=%0d timeout=%b",
                     name, tag, grant_valid, grant_idx, timeout, v, ix, t);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check after the edge.
    task automatic step(input string name, input int tag, input logic [15:0] r, input logic rl,
                        input logic v, input logic [3:0] ix, input logic t);
        exp_t e;
        @(negedge clk);
        req           = r;
        release_pulse = rl;
        e.valid = v;
        e.idx   = ix;
        e.to    = t;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s[%0d]: scoreboard empty, expected 1 entry", name, tag);
        end else begin
            e = sb.pop_front();
            compare(name, e.tag, e.valid, e.idx, e.to);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        req           = 16'h0000;
        release_pulse = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a grant.
        step("pre_reset_grant", 0, 16'h0020, 1'b0, 1'b1, 4'd5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_reset", 0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        req   = 16'h0000;
        rst_n = 1'b1;

        //                req       rel   valid idx    to
        vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0});
        vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0});
        vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0});
        vecs.push_back('{16'h0020, 1'b0, 1'b1, 4'd5,  1'b0});  // first grant from ptr 0
        vecs.push_back('{16'h0020, 1'b1, 1'b0, 4'd5,  1'b0});  // ptr -> 6
        vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'd5,  1'b0});
        vecs.push_back('{16'h8101, 1'b0, 1'b1, 4'd8,  1'b0});
        vecs.push_back('{16'h8101, 1'b1, 1'b0, 4'd8,  1'b0});
        vecs.push_back('{16'h8101, 1'b0, 1'b1, 4'd15, 1'b0});
        vecs.push_back('{16'h8101, 1'b1, 1'b0, 4'd15, 1'b0});  // ptr wraps to 0
        vecs.push_back('{16'h8101, 1'b0, 1'b1, 4'd0,  1'b0});
        vecs.push_back('{16'h8101, 1'b1, 1'b0, 4'd0,  1'b0});
        vecs.push_back('{16'h8101, 1'b0, 1'b1, 4'd8,  1'b0});
        vecs.push_back('{16'h8101, 1'b1, 1'b0, 4'd8,  1'b0});  // ptr -> 9
        vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'd8,  1'b0});  // release ignored in IDLE
        vecs.push_back('{16'h4000, 1'b0, 1'b1, 4'd14, 1'b0});
        vecs.push_back('{16'h4000, 1'b1, 1'b0, 4'd14, 1'b0});  // ptr -> 15
        vecs.push_back('{16'h0003, 1'b0, 1'b1, 4'd0,  1'b0});  // search wraps 15 -> 0
        vecs.push_back('{16'h0003, 1'b1, 1'b0, 4'd0,  1'b0});
        vecs.push_back('{16'h0003, 1'b0, 1'b1, 4'd1,  1'b0});
        vecs.push_back('{16'h0003, 1'b1, 1'b0, 4'd1,  1'b0});  // ptr -> 2
        vecs.push_back('{16'h0088, 1'b0, 1'b1, 4'd3,  1'b0});
        vecs.push_back('{16'h0080, 1'b0, 1'b0, 4'd3,  1'b0});  // holder withdraws
        vecs.push_back('{16'h0080, 1'b0, 1'b1, 4'd7,  1'b0});
        vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'd7,  1'b0});  // release + withdraw, ptr -> 8
        vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'd7,  1'b0});
        vecs.push_back('{16'h0002, 1'b0, 1'b1, 4'd1,  1'b0});
        vecs.push_back('{16'h0003, 1'b0, 1'b1, 4'd1,  1'b0});  // no preemption
        vecs.push_back('{16'h8003, 1'b0, 1'b1, 4'd1,  1'b0});
        vecs.push_back('{16'h8003, 1'b1, 1'b0, 4'd1,  1'b0});  // ptr -> 2
        vecs.push_back('{16'h8003, 1'b0, 1'b1, 4'd15, 1'b0});
        vecs.push_back('{16'h8003, 1'b1, 1'b0, 4'd15, 1'b0});  // ptr -> 0
        vecs.push_back('{16'h0004, 1'b0, 1'b1, 4'd2,  1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            step("vec", i, vecs[i].req, vecs[i].rel, vecs[i].exp_valid, vecs[i].exp_idx,
                 vecs[i].exp_to);
        end

`ifdef RR_TIMEOUT_EN
        // Grant to 2 began with the last vector; it lasts 4 cycles then is revoked.
        for (int i = 0; i < 3; i++) step("hold", i, 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0);
        step("revoke", 0, 16'h0004, 1'b0, 1'b0, 4'd2, 1'b1);
        step("regrant", 0, 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) step("hold2", i, 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0);
        step("release_at_limit", 0, 16'h0004, 1'b1, 1'b0, 4'd2, 1'b0);
        step("after_release", 0, 16'h0000, 1'b0, 1'b0, 4'd2, 1'b0);
`else
        for (int i = 0; i < 110; i++) step("persist", i, 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0);
        step("late_release", 0, 16'h0004, 1'b1, 1'b0, 4'd2, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
